// File: rtl/pc_ctrl.sv
// Program-counter sequencing controller: turns decoded control-flow requests into
// the PC select and supplies return addresses from a small return-address stack.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_INIT  | one hold cycle after reset, then RUN
// S_RUN   | normal sequencing: stall / halt / ret / call / jump / PC+1
// S_HALT  | halted, PC held, inputs ignored until reset
// S_FAULT | RAS overflow or underflow, PC held, sticky until reset
module pc_ctrl #(
    parameter int RAS_DEPTH = 4,
    parameter int AW        = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               instr_valid_in,
    input  logic                               jump_in,
    input  logic                               call_in,
    input  logic                               ret_in,
    input  logic                               halt_in,
    input  logic [AW-1:0]                      pc_in,
    output logic [1:0]                         ps_out,
    output logic [AW-1:0]                      ra_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     sp_out,
    output logic                               halted_out,
    output logic                               fault_out
);

    localparam int SPW = $clog2(RAS_DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(RAS_DEPTH);

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_IA   = 2'b10;
    localparam logic [1:0] PS_RA   = 2'b11;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SPW-1:0]    sp_q, sp_d;
    logic [AW-1:0]     ras_q [RAS_DEPTH];
    logic [AW-1:0]     ras_d [RAS_DEPTH];
    logic [1:0]        ps_d;
    logic              push;
    logic [AW-1:0]     push_val;

    assign push_val = pc_in + AW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            sp_q    <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    // Only the highest-priority request is acted on: halt > ret > call > jump.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        ps_d    = PS_HOLD;
        push    = 1'b0;
        unique case (state_q)
            S_INIT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (instr_valid_in) begin
                    if (halt_in) begin
                        state_d = S_HALT;
                    end else if (ret_in) begin
                        if (sp_q != '0) begin
                            ps_d = PS_RA;
                            sp_d = sp_q - SPW'(1);
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else if (call_in) begin
                        if (sp_q < SP_FULL) begin
                            ps_d = PS_IA;
                            push = 1'b1;
                            sp_d = sp_q + SPW'(1);
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else if (jump_in) begin
                        ps_d = PS_IA;
                    end else begin
                        ps_d = PS_INC;
                    end
                end
            end
            S_HALT, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_d[i] = ras_q[i];
            if (push && (SPW'(i) == sp_q)) begin
                ras_d[i] = push_val;
            end
        end
    end

    // Top of stack is the entry just below sp; an empty stack reads as zero.
    always_comb begin
        ra_out = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (SPW'(i + 1) == sp_q) begin
                ra_out = ras_q[i];
            end
        end
    end

    assign ps_out     = rst_n ? ps_d : PS_HOLD;
    assign sp_out     = sp_q;
    assign halted_out = (state_q == S_HALT);
    assign fault_out  = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl: reset, call/return, overflow,
// underflow/priority, stall/halt, address wrap and reset during a call.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_in, jump_in, call_in, ret_in, halt_in;
    logic [15:0] pc_in;
    logic [1:0]  ps_out;
    logic [15:0] ra_out;
    logic [2:0]  sp_out;
    logic        halted_out, fault_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_ctrl #(.RAS_DEPTH(4), .AW(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid_in (instr_valid_in),
        .jump_in        (jump_in),
        .call_in        (call_in),
        .ret_in         (ret_in),
        .halt_in        (halt_in),
        .pc_in          (pc_in),
        .ps_out         (ps_out),
        .ra_out         (ra_out),
        .sp_out         (sp_out),
        .halted_out     (halted_out),
        .fault_out      (fault_out)
    );

    task automatic drive(input logic v, input logic j, input logic c,
                         input logic r, input logic h, input logic [15:0] pc);
        instr_valid_in = v;
        jump_in        = j;
        call_in        = c;
        ret_in         = r;
        halt_in        = h;
        pc_in          = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic go_run();
        do_reset();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (sp_out !== 3'd0) begin n_err++; $display("FAIL reset_sp got %0d want 0", sp_out); end
        n_cmp++; if (ra_out !== 16'h0) begin n_err++; $display("FAIL reset_ra got %h want 0000", ra_out); end
        n_cmp++; if (halted_out !== 1'b0 || fault_out !== 1'b0) begin n_err++; $display("FAIL reset_flags got h=%b f=%b want 0 0", halted_out, fault_out); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL init_ps got %b want 00", ps_out); end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (ps_out !== 2'b01 || sp_out !== 3'd0 || ra_out !== 16'h0) begin
                n_err++; $display("FAIL seq_run[%0d] got ps=%b sp=%0d ra=%h want 01 0 0000", k, ps_out, sp_out, ra_out);
            end
            tick();
        end
    endtask

    task automatic test_call_ret();
        go_run();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
        n_cmp++; if (ps_out !== 2'b10) begin n_err++; $display("FAIL call_ps got %b want 10", ps_out); end
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0050);
        n_cmp++; if (sp_out !== 3'd1 || ra_out !== 16'h0011) begin n_err++; $display("FAIL call_push got sp=%0d ra=%h want 1 0011", sp_out, ra_out); end
        n_cmp++; if (ps_out !== 2'b10) begin n_err++; $display("FAIL jump_ps got %b want 10", ps_out); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0051);
        n_cmp++; if (sp_out !== 3'd1) begin n_err++; $display("FAIL jump_sp got %0d want 1", sp_out); end
        n_cmp++; if (ps_out !== 2'b11 || ra_out !== 16'h0011) begin n_err++; $display("FAIL ret_ps got ps=%b ra=%h want 11 0011", ps_out, ra_out); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011);
        n_cmp++; if (sp_out !== 3'd0 || ra_out !== 16'h0) begin n_err++; $display("FAIL ret_pop got sp=%0d ra=%h want 0 0000", sp_out, ra_out); end
    endtask

    task automatic test_overflow();
        logic [15:0] pcs [4];
        pcs[0] = 16'h0100; pcs[1] = 16'h0200; pcs[2] = 16'h0300; pcs[3] = 16'h0400;
        go_run();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pcs[k]);
            n_cmp++; if (ps_out !== 2'b10) begin n_err++; $display("FAIL nest_ps[%0d] got %b want 10", k, ps_out); end
            tick();
        end
        n_cmp++; if (sp_out !== 3'd4 || ra_out !== 16'h0401) begin n_err++; $display("FAIL nest_full got sp=%0d ra=%h want 4 0401", sp_out, ra_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0500);
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL ovf_ps got %b want 00", ps_out); end
        tick();
        n_cmp++; if (fault_out !== 1'b1 || sp_out !== 3'd4) begin n_err++; $display("FAIL ovf_fault got f=%b sp=%0d want 1 4", fault_out, sp_out); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0600);
            n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL fault_hold_ps[%0d] got %b want 00", k, ps_out); end
            tick();
            n_cmp++; if (sp_out !== 3'd4 || fault_out !== 1'b1 || ra_out !== 16'h0401) begin
                n_err++; $display("FAIL fault_hold[%0d] got sp=%0d f=%b ra=%h want 4 1 0401", k, sp_out, fault_out, ra_out);
            end
        end
    endtask

    task automatic test_underflow_priority();
        go_run();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL unf_ps got %b want 00", ps_out); end
        tick();
        n_cmp++; if (fault_out !== 1'b1 || sp_out !== 3'd0) begin n_err++; $display("FAIL unf_fault got f=%b sp=%0d want 1 0", fault_out, sp_out); end
        go_run();
        n_cmp++; if (fault_out !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b want 0", fault_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0030);
        n_cmp++; if (ps_out !== 2'b11 || ra_out !== 16'h0021) begin n_err++; $display("FAIL prio_ps got ps=%b ra=%h want 11 0021", ps_out, ra_out); end
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0021);
        n_cmp++; if (sp_out !== 3'd0 || ra_out !== 16'h0 || fault_out !== 1'b0) begin
            n_err++; $display("FAIL prio_pop got sp=%0d ra=%h f=%b want 0 0000 0", sp_out, ra_out, fault_out);
        end
    endtask

    task automatic test_stall_halt();
        go_run();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0041);
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL stall_ps got %b want 00", ps_out); end
        tick();
        n_cmp++; if (sp_out !== 3'd1 || ra_out !== 16'h0041 || halted_out !== 1'b0 || fault_out !== 1'b0) begin
            n_err++; $display("FAIL stall_state got sp=%0d ra=%h h=%b f=%b want 1 0041 0 0", sp_out, ra_out, halted_out, fault_out);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0041);
        n_cmp++; if (ps_out !== 2'b01) begin n_err++; $display("FAIL post_stall_ps got %b want 01", ps_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL halt_ps got %b want 00", ps_out); end
        tick();
        n_cmp++; if (halted_out !== 1'b1 || sp_out !== 3'd1 || ra_out !== 16'h0041) begin
            n_err++; $display("FAIL halt_state got h=%b sp=%0d ra=%h want 1 1 0041", halted_out, sp_out, ra_out);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0043);
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL halt_ign_ps got %b want 00", ps_out); end
        tick();
        n_cmp++; if (halted_out !== 1'b1 || sp_out !== 3'd1) begin n_err++; $display("FAIL halt_ign got h=%b sp=%0d want 1 1", halted_out, sp_out); end
    endtask

    task automatic test_wrap_reset();
        go_run();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        n_cmp++; if (ps_out !== 2'b10) begin n_err++; $display("FAIL wrap_ps got %b want 10", ps_out); end
        tick();
        n_cmp++; if (sp_out !== 3'd1 || ra_out !== 16'h0000) begin n_err++; $display("FAIL wrap_push got sp=%0d ra=%h want 1 0000", sp_out, ra_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0005);
        tick();
        n_cmp++; if (sp_out !== 3'd2 || ra_out !== 16'h0006) begin n_err++; $display("FAIL b2b_push got sp=%0d ra=%h want 2 0006", sp_out, ra_out); end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
        tick();
        n_cmp++; if (sp_out !== 3'd1 || ra_out !== 16'h0000) begin n_err++; $display("FAIL wrap_pop got sp=%0d ra=%h want 1 0000", sp_out, ra_out); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL rst_call_ps got %b want 00", ps_out); end
        tick();
        n_cmp++; if (sp_out !== 3'd0 || ra_out !== 16'h0 || ps_out !== 2'b00) begin
            n_err++; $display("FAIL rst_call got sp=%0d ra=%h ps=%b want 0 0000 00", sp_out, ra_out, ps_out);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        n_cmp++; if (ps_out !== 2'b00) begin n_err++; $display("FAIL rst_init_ps got %b want 00", ps_out); end
        tick();
        n_cmp++; if (ps_out !== 2'b01) begin n_err++; $display("FAIL rst_run_ps got %b want 01", ps_out); end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        test_reset();
        test_call_ret();
        test_overflow();
        test_underflow_priority();
        test_stall_halt();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
